// File: rtl/mixer_pkg.sv
// Shared types and constants for the DAC voice mixer.
// State encoding, DAC word format, saturation bounds and dither LFSR setup.
package mixer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SCALE,
        OUT
    } state_t;

    localparam int DAC_W = 12;
    localparam logic [DAC_W-1:0] DAC_MID = 12'h800;

    localparam int SAT_MAX = 2047;
    localparam int SAT_MIN = -2048;

    // Fibonacci taps 16,14,13,11 as a mask on bits 15,13,12,10
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/mixer_saturate.sv
// Scales the voice sum, saturates to 12-bit signed, converts to offset binary.
// Ports: sum (accumulator), dither (added before shift), dac (offset binary), clip.
module mixer_saturate
    import mixer_pkg::*;
#(
    parameter int ACC_W = 21,
    parameter int SHIFT = 3
) (
    input  logic [ACC_W-1:0] sum,
    input  logic [7:0]       dither,
    output logic [DAC_W-1:0] dac,
    output logic             clip
);

    // One extra bit so sum plus dither can never wrap
    localparam int W = ACC_W + 1;
    localparam logic signed [W-1:0] HI = W'(SAT_MAX);
    localparam logic signed [W-1:0] LO = W'(SAT_MIN);

    logic signed [W-1:0] biased;
    logic signed [W-1:0] shifted;
    logic [DAC_W-1:0]    sat;

    always_comb begin
        biased  = $signed({sum[ACC_W-1], sum})
                + $signed({{(W-8){1'b0}}, dither});
        shifted = biased >>> SHIFT;
        clip    = 1'b0;
        sat     = shifted[DAC_W-1:0];
        if (shifted > HI) begin
            sat  = HI[DAC_W-1:0];
            clip = 1'b1;
        end else if (shifted < LO) begin
            sat  = LO[DAC_W-1:0];
            clip = 1'b1;
        end
        dac = {~sat[DAC_W-1], sat[DAC_W-2:0]};
    end

endmodule

// File: rtl/dac_voice_mixer.sv
// Fetches one sample per voice on each sample_ena, sums, scales and drives dac_data.
// Ports: clk, reset (sync, active-high), sample_ena, voice_rd/voice_sel/voice_data/
// voice_valid handshake, dac_data, frame_done, clip, overrun (sticky).
// Option: define MIXER_DITHER_EN to add LFSR rectangular dither before the shift.
module dac_voice_mixer
    import mixer_pkg::*;
#(
    parameter int NUM_VOICES = 8,
    parameter int VOICE_W    = 18,
    parameter int SHIFT      = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sample_ena,
    output logic                          voice_rd,
    output logic [$clog2(NUM_VOICES)-1:0] voice_sel,
    input  logic [VOICE_W-1:0]            voice_data,
    input  logic                          voice_valid,
    output logic [DAC_W-1:0]              dac_data,
    output logic                          frame_done,
    output logic                          clip,
    output logic                          overrun
);

    localparam int SEL_W = $clog2(NUM_VOICES);
    localparam int ACC_W = VOICE_W + SEL_W;
    localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_VOICES - 1);

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sample_ext;
    logic [DAC_W-1:0] sat_dac;
    logic             sat_clip;
    logic [DAC_W-1:0] sat_q;
    logic             sat_clip_q;
    logic [7:0]       dither;

    assign sample_ext = {{SEL_W{voice_data[VOICE_W-1]}}, voice_data};

`ifdef MIXER_DITHER_EN
    localparam logic [7:0] DITHER_MASK = 8'((1 << SHIFT) - 1);

    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else if (state == SCALE) begin
            lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
        end
    end

    assign dither = lfsr[7:0] & DITHER_MASK;
`else
    assign dither = '0;
`endif

    mixer_saturate #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT)
    ) u_sat (
        .sum    (acc),
        .dither (dither),
        .dac    (sat_dac),
        .clip   (sat_clip)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            acc        <= '0;
            voice_sel  <= '0;
            voice_rd   <= 1'b0;
            sat_q      <= DAC_MID;
            sat_clip_q <= 1'b0;
            dac_data   <= DAC_MID;
            frame_done <= 1'b0;
            clip       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            clip       <= 1'b0;
            if (sample_ena && state != IDLE) begin
                overrun <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (sample_ena) begin
                        acc       <= '0;
                        voice_sel <= '0;
                        voice_rd  <= 1'b1;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (voice_valid) begin
                        acc <= acc + sample_ext;
                        if (voice_sel == LAST) begin
                            voice_rd <= 1'b0;
                            state    <= SCALE;
                        end else begin
                            voice_sel <= voice_sel + SEL_W'(1);
                        end
                    end
                end
                SCALE: begin
                    sat_q      <= sat_dac;
                    sat_clip_q <= sat_clip;
                    state      <= OUT;
                end
                OUT: begin
                    dac_data   <= sat_q;
                    frame_done <= 1'b1;
                    clip       <= sat_clip_q;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dac_voice_mixer.sv
// Self-checking bench for dac_voice_mixer (default build, dither disabled).
// Vector table plus handwritten overrun and mid-frame reset sequences.
module tb_dac_voice_mixer;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_ena;
    logic        voice_rd;
    logic [2:0]  voice_sel;
    logic [17:0] voice_data;
    logic        voice_valid;
    logic [11:0] dac_data;
    logic        frame_done;
    logic        clip;
    logic        overrun;

    dac_voice_mixer dut (
        .clk         (clk),
        .reset       (reset),
        .sample_ena  (sample_ena),
        .voice_rd    (voice_rd),
        .voice_sel   (voice_sel),
        .voice_data  (voice_data),
        .voice_valid (voice_valid),
        .dac_data    (dac_data),
        .frame_done  (frame_done),
        .clip        (clip),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;

    logic [17:0] voices [8];
    bit          slow = 1'b0;
    int          wcnt = 0;

    // Voice source: slow mode acknowledges on every third requested cycle
    always_comb begin
        voice_data  = voices[voice_sel];
        voice_valid = slow ? (voice_rd && wcnt == 2) : 1'b1;
    end

    always @(posedge clk) begin
        if (voice_rd && !voice_valid) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    typedef struct packed {
        logic [11:0] dac;
        logic        clp;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (frame_done === 1'b1) begin
            exp_t e;
            n_done++;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_frame_done: got 1 expected 0");
            end else begin
                e = sb.pop_front();
                check("dac_data", 32'(dac_data), 32'(e.dac));
                check("clip", 32'(clip), 32'(e.clp));
            end
        end
    end

    task automatic set_voices(input int base, input int step);
        for (int i = 0; i < 8; i++) voices[i] = 18'(base + step * i);
    endtask

    task automatic run_frame(input bit slw, input int lat, input exp_t e);
        int  edges;
        bit  got;
        @(negedge clk);
        slow       = slw;
        sample_ena = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1 sample_ena = 1'b0;
        edges = 1;
        got   = 1'b0;
        while (!got && edges < 200) begin
            @(posedge clk);
            edges++;
            #1 if (frame_done) got = 1'b1;
        end
        check("latency", 32'(edges), 32'(lat));
        @(posedge clk);
        #1 check("done_pulse", 32'(frame_done), 32'd0);
        slow = 1'b0;
    endtask

    typedef struct {
        int          base;
        int          step;
        bit          slw;
        logic [11:0] dac;
        logic        clp;
        int          lat;
    } vec_t;

    vec_t vec [11];

    initial begin
        int snap;
        int k;

        vec[0]  = '{0,       0,    1'b0, 12'h800, 1'b0, 11};
        vec[1]  = '{1000,    0,    1'b0, 12'hBE8, 1'b0, 11};
        vec[2]  = '{131071,  0,    1'b0, 12'hFFF, 1'b1, 11};
        vec[3]  = '{-131072, 0,    1'b0, 12'h000, 1'b1, 11};
        vec[4]  = '{1000,    0,    1'b1, 12'hBE8, 1'b0, 27};
        vec[5]  = '{0,       100,  1'b0, 12'h95E, 1'b0, 11};
        vec[6]  = '{-1000,   0,    1'b0, 12'h418, 1'b0, 11};
        vec[7]  = '{0,       -1,   1'b0, 12'h7FC, 1'b0, 11};
        vec[8]  = '{2047,    0,    1'b0, 12'hFFF, 1'b0, 11};
        vec[9]  = '{2048,    0,    1'b0, 12'hFFF, 1'b1, 11};
        vec[10] = '{-2048,   0,    1'b0, 12'h000, 1'b0, 11};

        reset      = 1'b1;
        sample_ena = 1'b0;
        set_voices(0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_dac", 32'(dac_data), 32'h800);
        check("rst_rd", 32'(voice_rd), 32'd0);
        check("rst_sel", 32'(voice_sel), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_clip", 32'(clip), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("idle_dac", 32'(dac_data), 32'h800);

        foreach (vec[i]) begin
            set_voices(vec[i].base, vec[i].step);
            run_frame(vec[i].slw, vec[i].lat, '{vec[i].dac, vec[i].clp});
        end
        check("no_ovr", 32'(overrun), 32'd0);

        // Second strobe mid-frame: flagged, ignored
        set_voices(1000, 0);
        snap = n_done;
        @(negedge clk);
        sample_ena = 1'b1;
        sb.push_back('{12'hBE8, 1'b0});
        @(posedge clk);
        #1 sample_ena = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        sample_ena = 1'b1;
        @(posedge clk);
        #1 sample_ena = 1'b0;
        check("ovr_set", 32'(overrun), 32'd1);
        repeat (30) @(posedge clk);
        #1;
        check("ovr_frames", 32'(n_done - snap), 32'd1);
        check("ovr_sticky", 32'(overrun), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check("ovr_clr", 32'(overrun), 32'd0);
        check("ovr_rst_dac", 32'(dac_data), 32'h800);

        // Reset while requesting voice 5
        @(negedge clk);
        sample_ena = 1'b1;
        @(posedge clk);
        #1 sample_ena = 1'b0;
        k = 0;
        while (voice_sel != 3'd5 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("reach_v5", 32'(voice_sel), 32'd5);
        reset = 1'b1;
        snap  = n_done;
        @(posedge clk);
        #1 reset = 1'b0;
        check("mid_rd", 32'(voice_rd), 32'd0);
        check("mid_sel", 32'(voice_sel), 32'd0);
        check("mid_dac", 32'(dac_data), 32'h800);
        repeat (20) @(posedge clk);
        #1 check("mid_no_done", 32'(n_done - snap), 32'd0);
        set_voices(0, 100);
        run_frame(1'b0, 11, '{12'h95E, 1'b0});

        repeat (3) @(posedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dac_voice_mixer.md
# dac_voice_mixer

Upstream feeder for the SPI DAC output stage. On each sample strobe from the DAC driver, it sequentially fetches one signed sample from each voice through a request/valid handshake and accumulates them. It then scales the sum, saturates it and converts it to 12-bit offset binary. The result is held on `dac_data` for the DAC driver's next conversion.

## Interface
- `NUM_VOICES`, 8: voices summed per frame; power of two, 2..16.
- `VOICE_W`, 18: signed voice sample width.
- `SHIFT`, 3: arithmetic right shift applied to the sum; 0..8.
- `clk`  in  1  system clock.
- `reset`  in  1  reset; synchronous, active-high.
- `sample_ena`  in  1  one-cycle strobe from the DAC driver; starts a frame.
- `voice_rd`  out  1  request for the voice selected by `voice_sel`.
- `voice_sel`  out  log2(NUM_VOICES)  index of the requested voice.
- `voice_data`  in  VOICE_W  signed voice sample; valid when `voice_valid`=1.
- `voice_valid`  in  1  source acknowledge; may be high in the same cycle as `voice_rd`.
- `dac_data`  out  12  offset-binary DAC word; held between frames.
- `frame_done`  out  1  one-cycle pulse; `dac_data` was updated this cycle.
- `clip`  out  1  one-cycle pulse coincident with `frame_done` when saturation occurred.
- `overrun`  out  1  sticky; a `sample_ena` arrived while a frame was in progress.

## Operation
- Reset values:
  - state IDLE, accumulator 0, `voice_sel` 0, `voice_rd` 0.
  - `dac_data` 12'h800 (midscale).
  - `frame_done`, `clip`, `overrun` all 0.
- IDLE: on `sample_ena`=1, clear the accumulator and `voice_sel`, then go to REQ.
- REQ:
  - `voice_rd`=1; `voice_sel` stays stable until accepted.
  - A cycle with `voice_valid`=1 accepts: the accumulator adds sign-extended `voice_data`.
  - After acceptance, `voice_sel` increments, or the block goes to SCALE after voice NUM_VOICES-1.
  - A cycle with `voice_valid`=0 holds everything.
- SCALE: register `sum >>> SHIFT` and saturate it to signed [-2048, 2047]. Record whether saturation occurred. Go to OUT.
- OUT:
  - `dac_data` <= saturated value with MSB inverted (offset binary).
  - `frame_done`=1 and `clip`=saturation flag on the following cycle.
  - Return to IDLE.
- Accumulator width is VOICE_W + log2(NUM_VOICES), so it never wraps.
- `sample_ena` outside IDLE is ignored and sets `overrun`=1. Only reset clears `overrun`.
- `voice_valid` while `voice_rd`=0 is ignored.
- Reset in any state aborts the frame and restores all reset values, including `dac_data`=12'h800.

## Timing
- With `voice_valid` tied high, `dac_data` and `frame_done` change 11 edges after the edge that samples `sample_ena`:
  - 1 edge: IDLE to REQ.
  - NUM_VOICES edges: one accept per voice.
  - 2 edges: SCALE, OUT.
- General latency: 3 + Σ(cycles per voice accept).
- `dac_data` changes only at the OUT edge and is otherwise stable. It is guaranteed stable for any DAC frame period longer than the mix latency.
- `voice_rd` is a registered output; `voice_sel` changes only on the edge after an accept.

## Configuration
- `MIXER_DITHER_EN` defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1; reset to seed) advances once per frame in SCALE.
  - Its low SHIFT bits are added to the sum before the shift, giving TPDF-free rectangular dither.
  - Saturation is applied after the add.
- Undefined: plain truncating shift; no LFSR logic is present. All test values below assume undefined.

## Structure
- Package `mixer_pkg`: state enum (IDLE, REQ, SCALE, OUT), DAC width 12, midscale constant 12'h800, saturation bounds, LFSR seed and taps.
- Sub-module `mixer_saturate`: shift, saturate, offset-binary conversion and clip flag, parameterised by accumulator width and SHIFT. The top level owns the FSM, handshake and registers.

## Test plan
- All voices 0, `voice_valid` tied 1, one `sample_ena` -> `dac_data`=12'h800, `frame_done` 11 edges later, `clip`=0.
- All voices +1000 -> sum 8000, >>>3 = 1000 -> `dac_data`=12'hBE8, `clip`=0.
- All voices +131071 -> `dac_data`=12'hFFF, `clip`=1. All voices -131072 -> `dac_data`=12'h000, `clip`=1.
- `voice_valid` high only every 3rd cycle -> `voice_sel` holds for 3 cycles per voice, latency 27 edges, same result as the +1000 case.
- Second `sample_ena` 4 cycles after the first -> `overrun`=1 and stays 1, exactly one `frame_done`. Later reset -> `overrun`=0, `dac_data`=12'h800.
- Reset asserted during REQ at voice 5 -> IDLE, `voice_rd`=0, no `frame_done`. The next frame computes correctly from voice 0.
